// File: rtl/reorder_buffer.sv
// In-order reorder buffer: 2-wide allocate, 3-port writeback, 2-wide in-order commit.
// Optional `ROB_FLUSH_EN adds a flush input that empties the buffer at the next edge.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int PREG_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef ROB_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic [1:0]            alloc_valid,
  input  logic [2*PREG_W-1:0]   alloc_rd,
  input  logic [2*PREG_W-1:0]   alloc_old_rd,
  input  logic [1:0]            alloc_regwrite,
  output logic                  alloc_ready,
  output logic [2*IDX_W-1:0]    alloc_idx,
  input  logic [2:0]            wb_valid,
  input  logic [3*IDX_W-1:0]    wb_idx,
  input  logic [3*DATA_W-1:0]   wb_data,
  output logic [1:0]            commit_valid,
  output logic [2*PREG_W-1:0]   commit_rd,
  output logic [2*PREG_W-1:0]   commit_old_rd,
  output logic [2*DATA_W-1:0]   commit_data,
  output logic [1:0]            commit_regwrite,
  output logic [IDX_W:0]        count
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [PREG_W-1:0] rd;
    logic [PREG_W-1:0] old_rd;
    logic              regwrite;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             rob_q [DEPTH];
  entry_t             rob_d [DEPTH];
  logic [IDX_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         commit_valid_q, commit_valid_d;
  logic [2*PREG_W-1:0] commit_rd_q, commit_rd_d;
  logic [2*PREG_W-1:0] commit_old_rd_q, commit_old_rd_d;
  logic [2*DATA_W-1:0] commit_data_q, commit_data_d;
  logic [1:0]         commit_regwrite_q, commit_regwrite_d;

  logic [IDX_W-1:0]   head1, tail1, wb_i;
  logic               do_alloc, commit0, commit1;
  logic [CNT_W-1:0]   n_alloc, n_commit;

  // Readiness looks only at the registered count; same-cycle commits are not bypassed.
  assign alloc_ready     = (count_q <= CNT_W'(DEPTH - 2));
  assign tail1           = tail_q + IDX_ONE;
  assign alloc_idx       = {tail1, tail_q};
  assign count           = count_q;
  assign commit_valid    = commit_valid_q;
  assign commit_rd       = commit_rd_q;
  assign commit_old_rd   = commit_old_rd_q;
  assign commit_data     = commit_data_q;
  assign commit_regwrite = commit_regwrite_q;

  always_comb begin
    rob_d             = rob_q;
    head_d            = head_q;
    tail_d            = tail_q;
    count_d           = count_q;
    commit_valid_d    = '0;
    commit_rd_d       = '0;
    commit_old_rd_d   = '0;
    commit_data_d     = '0;
    commit_regwrite_d = '0;
    wb_i              = '0;
    head1    = head_q + IDX_ONE;
    do_alloc = alloc_ready && alloc_valid[0];
    n_alloc  = '0;
    if (do_alloc) n_alloc = alloc_valid[1] ? CNT_W'(2) : CNT_W'(1);
    commit0  = rob_q[head_q].valid && rob_q[head_q].done;
    commit1  = commit0 && rob_q[head1].valid && rob_q[head1].done;
    n_commit = commit1 ? CNT_W'(2) : (commit0 ? CNT_W'(1) : CNT_W'(0));

    // Ascending FU order so the highest-numbered FU wins on an index collision.
    for (int f = 0; f < 3; f++) begin
      wb_i = wb_idx[f*IDX_W +: IDX_W];
      if (wb_valid[f] && rob_q[wb_i].valid) begin
        rob_d[wb_i].done = 1'b1;
        rob_d[wb_i].data = wb_data[f*DATA_W +: DATA_W];
      end
    end

    if (commit0) begin
      commit_valid_d[0]               = 1'b1;
      commit_rd_d[0 +: PREG_W]        = rob_q[head_q].rd;
      commit_old_rd_d[0 +: PREG_W]    = rob_q[head_q].regwrite ? rob_q[head_q].old_rd : '0;
      commit_data_d[0 +: DATA_W]      = rob_q[head_q].data;
      commit_regwrite_d[0]            = rob_q[head_q].regwrite;
      rob_d[head_q]                   = '0;
    end
    if (commit1) begin
      commit_valid_d[1]               = 1'b1;
      commit_rd_d[PREG_W +: PREG_W]   = rob_q[head1].rd;
      commit_old_rd_d[PREG_W +: PREG_W] = rob_q[head1].regwrite ? rob_q[head1].old_rd : '0;
      commit_data_d[DATA_W +: DATA_W] = rob_q[head1].data;
      commit_regwrite_d[1]            = rob_q[head1].regwrite;
      rob_d[head1]                    = '0;
    end

    // Allocation needs two free slots pre-edge, so it never lands on a committing entry.
    if (do_alloc) begin
      rob_d[tail_q].valid    = 1'b1;
      rob_d[tail_q].done     = 1'b0;
      rob_d[tail_q].rd       = alloc_rd[0 +: PREG_W];
      rob_d[tail_q].old_rd   = alloc_old_rd[0 +: PREG_W];
      rob_d[tail_q].regwrite = alloc_regwrite[0];
      rob_d[tail_q].data     = '0;
      if (alloc_valid[1]) begin
        rob_d[tail1].valid    = 1'b1;
        rob_d[tail1].done     = 1'b0;
        rob_d[tail1].rd       = alloc_rd[PREG_W +: PREG_W];
        rob_d[tail1].old_rd   = alloc_old_rd[PREG_W +: PREG_W];
        rob_d[tail1].regwrite = alloc_regwrite[1];
        rob_d[tail1].data     = '0;
      end
    end

    head_d  = head_q + n_commit[IDX_W-1:0];
    tail_d  = tail_q + n_alloc[IDX_W-1:0];
    count_d = count_q + n_alloc - n_commit;

`ifdef ROB_FLUSH_EN
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) rob_d[i] = '0;
      head_d            = '0;
      tail_d            = '0;
      count_d           = '0;
      commit_valid_d    = '0;
      commit_rd_d       = '0;
      commit_old_rd_d   = '0;
      commit_data_d     = '0;
      commit_regwrite_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rob_q[i] <= '0;
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      commit_valid_q    <= '0;
      commit_rd_q       <= '0;
      commit_old_rd_q   <= '0;
      commit_data_q     <= '0;
      commit_regwrite_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) rob_q[i] <= rob_d[i];
      head_q            <= head_d;
      tail_q            <= tail_d;
      count_q           <= count_d;
      commit_valid_q    <= commit_valid_d;
      commit_rd_q       <= commit_rd_d;
      commit_old_rd_q   <= commit_old_rd_d;
      commit_data_q     <= commit_data_d;
      commit_regwrite_q <= commit_regwrite_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer; the flush scenario is built only
// when ROB_FLUSH_EN is defined.
module tb_reorder_buffer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [1:0]  alloc_valid;
  logic [11:0] alloc_rd;
  logic [11:0] alloc_old_rd;
  logic [1:0]  alloc_regwrite;
  logic        alloc_ready;
  logic [7:0]  alloc_idx;
  logic [2:0]  wb_valid;
  logic [11:0] wb_idx;
  logic [95:0] wb_data;
  logic [1:0]  commit_valid;
  logic [11:0] commit_rd;
  logic [11:0] commit_old_rd;
  logic [63:0] commit_data;
  logic [1:0]  commit_regwrite;
  logic [4:0]  count;

  int tests_run;
  int tests_failed;

  reorder_buffer dut (
    .clk             (clk),
    .rst_n           (rst_n),
`ifdef ROB_FLUSH_EN
    .flush           (flush),
`endif
    .alloc_valid     (alloc_valid),
    .alloc_rd        (alloc_rd),
    .alloc_old_rd    (alloc_old_rd),
    .alloc_regwrite  (alloc_regwrite),
    .alloc_ready     (alloc_ready),
    .alloc_idx       (alloc_idx),
    .wb_valid        (wb_valid),
    .wb_idx          (wb_idx),
    .wb_data         (wb_data),
    .commit_valid    (commit_valid),
    .commit_rd       (commit_rd),
    .commit_old_rd   (commit_old_rd),
    .commit_data     (commit_data),
    .commit_regwrite (commit_regwrite),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush          = 1'b0;
    alloc_valid    = 2'b00;
    alloc_rd       = '0;
    alloc_old_rd   = '0;
    alloc_regwrite = 2'b00;
    wb_valid       = 3'b000;
    wb_idx         = '0;
    wb_data        = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_alloc(input logic [1:0] v, input logic [5:0] rd1, input logic [5:0] rd0,
                           input logic [5:0] old1, input logic [5:0] old0, input logic [1:0] rw);
    alloc_valid    = v;
    alloc_rd       = {rd1, rd0};
    alloc_old_rd   = {old1, old0};
    alloc_regwrite = rw;
  endtask

  task automatic set_wb(input int fu, input logic [3:0] idx, input logic [31:0] data);
    wb_valid[fu]           = 1'b1;
    wb_idx[fu*4 +: 4]      = idx;
    wb_data[fu*32 +: 32]   = data;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if (count !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    tests_run++;
    if (alloc_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready got %b want 1", alloc_ready); end
    tests_run++;
    if (commit_valid !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_cv got %b want 00", commit_valid); end
    tests_run++;
    if (alloc_idx !== 8'h10) begin tests_failed++; $display("[TB] FAIL reset_idx got %h want 10", alloc_idx); end
    // alloc_valid[1] without [0] must be ignored
    set_alloc(2'b10, 6'd9, 6'd9, 6'd1, 6'd1, 2'b11);
    tick();
    idle_inputs();
    tests_run++;
    if (count !== 5'd0) begin tests_failed++; $display("[TB] FAIL slot1_only_count got %0d want 0", count); end
  endtask

  task automatic test_basic_commit();
    set_alloc(2'b11, 6'd6, 6'd5, 6'd2, 6'd1, 2'b11);
    tests_run++;
    if (alloc_idx !== 8'h10) begin tests_failed++; $display("[TB] FAIL t1_alloc_idx got %h want 10", alloc_idx); end
    tick();
    idle_inputs();
    tests_run++;
    if (count !== 5'd2) begin tests_failed++; $display("[TB] FAIL t1_count2 got %0d want 2", count); end
    set_wb(0, 4'd1, 32'h11);
    tick();
    idle_inputs();
    tests_run++;
    if (commit_valid !== 2'b00) begin tests_failed++; $display("[TB] FAIL t1_no_commit_idx1 got %b want 00", commit_valid); end
    set_wb(1, 4'd0, 32'h10);
    tick();
    idle_inputs();
    tests_run++;
    if (commit_valid !== 2'b00) begin tests_failed++; $display("[TB] FAIL t1_latency got %b want 00", commit_valid); end
    tick();
    tests_run++;
    if (commit_valid !== 2'b11) begin tests_failed++; $display("[TB] FAIL t1_cv got %b want 11", commit_valid); end
    tests_run++;
    if (commit_rd !== {6'd6, 6'd5}) begin tests_failed++; $display("[TB] FAIL t1_rd got %h want %h", commit_rd, {6'd6, 6'd5}); end
    tests_run++;
    if (commit_old_rd !== {6'd2, 6'd1}) begin tests_failed++; $display("[TB] FAIL t1_old_rd got %h want %h", commit_old_rd, {6'd2, 6'd1}); end
    tests_run++;
    if (commit_data !== {32'h11, 32'h10}) begin tests_failed++; $display("[TB] FAIL t1_data got %h want %h", commit_data, {32'h11, 32'h10}); end
    tests_run++;
    if (commit_regwrite !== 2'b11) begin tests_failed++; $display("[TB] FAIL t1_rw got %b want 11", commit_regwrite); end
    tests_run++;
    if (count !== 5'd0) begin tests_failed++; $display("[TB] FAIL t1_count0 got %0d want 0", count); end
    tick();
    tests_run++;
    if (commit_valid !== 2'b00) begin tests_failed++; $display("[TB] FAIL t1_one_cycle got %b want 00", commit_valid); end
  endtask

  task automatic test_partial_commit();
    // head/tail are at 2 after the previous scenario
    set_alloc(2'b11, 6'd8, 6'd7, 6'd4, 6'd3, 2'b01);
    tests_run++;
    if (alloc_idx !== 8'h32) begin tests_failed++; $display("[TB] FAIL t2_alloc_idx got %h want 32", alloc_idx); end
    tick();
    idle_inputs();
    set_wb(0, 4'd2, 32'hDEAD);
    tick();
    idle_inputs();
    tick();
    tests_run++;
    if (commit_valid !== 2'b01) begin tests_failed++; $display("[TB] FAIL t2_cv got %b want 01", commit_valid); end
    tests_run++;
    if (commit_data[31:0] !== 32'hDEAD) begin tests_failed++; $display("[TB] FAIL t2_data got %h want dead", commit_data[31:0]); end
    tests_run++;
    if (commit_rd[5:0] !== 6'd7) begin tests_failed++; $display("[TB] FAIL t2_rd got %0d want 7", commit_rd[5:0]); end
    tests_run++;
    if (count !== 5'd1) begin tests_failed++; $display("[TB] FAIL t2_count got %0d want 1", count); end
    tick();
    tests_run++;
    if (commit_valid !== 2'b00) begin tests_failed++; $display("[TB] FAIL t2_idx3_stays got %b want 00", commit_valid); end
    set_wb(2, 4'd3, 32'hBEEF);
    tick();
    idle_inputs();
    tick();
    tests_run++;
    if (commit_valid !== 2'b01) begin tests_failed++; $display("[TB] FAIL t2_cv2 got %b want 01", commit_valid); end
    tests_run++;
    if (commit_old_rd[5:0] !== 6'd0) begin tests_failed++; $display("[TB] FAIL t2_old_rd_norw got %0d want 0", commit_old_rd[5:0]); end
    tests_run++;
    if (commit_regwrite !== 2'b00) begin tests_failed++; $display("[TB] FAIL t2_rw got %b want 00", commit_regwrite); end
    tests_run++;
    if (commit_data[31:0] !== 32'hBEEF) begin tests_failed++; $display("[TB] FAIL t2_data2 got %h want beef", commit_data[31:0]); end
  endtask

  task automatic test_fill();
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      set_alloc(2'b11, 6'd1, 6'd1, 6'd0, 6'd0, 2'b11);
      tick();
    end
    idle_inputs();
    tests_run++;
    if (count !== 5'd14 || alloc_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL t3_at14 got count=%0d ready=%b want 14/1", count, alloc_ready); end
    set_alloc(2'b01, 6'd1, 6'd1, 6'd0, 6'd0, 2'b11);
    tick();
    tests_run++;
    if (count !== 5'd15 || alloc_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL t3_at15 got count=%0d ready=%b want 15/0", count, alloc_ready); end
    set_alloc(2'b11, 6'd1, 6'd1, 6'd0, 6'd0, 2'b11);
    tick();
    idle_inputs();
    tests_run++;
    if (count !== 5'd15 || alloc_idx[3:0] !== 4'd15) begin tests_failed++; $display("[TB] FAIL t3_drop15 got count=%0d tail=%0d want 15/15", count, alloc_idx[3:0]); end
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      set_alloc(2'b11, 6'd1, 6'd1, 6'd0, 6'd0, 2'b11);
      tick();
    end
    tests_run++;
    if (count !== 5'd16 || alloc_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL t3_at16 got count=%0d ready=%b want 16/0", count, alloc_ready); end
    tick();
    idle_inputs();
    tests_run++;
    if (count !== 5'd16 || alloc_idx !== 8'h10) begin tests_failed++; $display("[TB] FAIL t3_drop16 got count=%0d idx=%h want 16/10", count, alloc_idx); end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      set_alloc(2'b01, 6'd0, 6'(i + 1), 6'd0, 6'(i + 2), 2'b01);
      tests_run++;
      if (alloc_idx[3:0] !== 4'(i % 16)) begin tests_failed++; $display("[TB] FAIL t4_idx_%0d got %0d want %0d", i, alloc_idx[3:0], i % 16); end
      tick();
      idle_inputs();
      set_wb(i % 3, 4'(i % 16), 32'(100 + i));
      tick();
      idle_inputs();
      tick();
      tests_run++;
      if (commit_valid !== 2'b01 || commit_rd[5:0] !== 6'(i + 1) || commit_data[31:0] !== 32'(100 + i)) begin
        tests_failed++;
        $display("[TB] FAIL t4_commit_%0d got cv=%b rd=%0d data=%0d want 01/%0d/%0d", i, commit_valid, commit_rd[5:0], commit_data[31:0], i + 1, 100 + i);
      end
    end
    tests_run++;
    if (count !== 5'd0) begin tests_failed++; $display("[TB] FAIL t4_count got %0d want 0", count); end
  endtask

  task automatic test_wb_collision();
    apply_reset();
    set_alloc(2'b11, 6'd11, 6'd10, 6'd0, 6'd0, 2'b11);
    tick();
    set_alloc(2'b11, 6'd13, 6'd12, 6'd0, 6'd0, 2'b11);
    tick();
    idle_inputs();
    set_wb(0, 4'd3, 32'h1);
    set_wb(1, 4'd5, 32'h77);
    set_wb(2, 4'd3, 32'h2);
    tick();
    idle_inputs();
    set_wb(0, 4'd0, 32'hA);
    set_wb(1, 4'd1, 32'hB);
    set_wb(2, 4'd2, 32'hC);
    tick();
    idle_inputs();
    tick();
    tests_run++;
    if (commit_valid !== 2'b11 || commit_data !== {32'hB, 32'hA}) begin tests_failed++; $display("[TB] FAIL t5_first got cv=%b data=%h want 11/%h", commit_valid, commit_data, {32'hB, 32'hA}); end
    tick();
    tests_run++;
    if (commit_valid !== 2'b11 || commit_data !== {32'h2, 32'hC}) begin tests_failed++; $display("[TB] FAIL t5_fu2_wins got cv=%b data=%h want 11/%h", commit_valid, commit_data, {32'h2, 32'hC}); end
    tests_run++;
    if (commit_rd !== {6'd13, 6'd12}) begin tests_failed++; $display("[TB] FAIL t5_rd got %h want %h", commit_rd, {6'd13, 6'd12}); end
    // idx5 was free when written back; once allocated it must still be pending
    set_alloc(2'b11, 6'd15, 6'd14, 6'd0, 6'd0, 2'b11);
    tick();
    idle_inputs();
    set_wb(0, 4'd4, 32'h44);
    tick();
    idle_inputs();
    tick();
    tests_run++;
    if (commit_valid !== 2'b01) begin tests_failed++; $display("[TB] FAIL t5_free_wb_ignored got %b want 01", commit_valid); end
  endtask

  task automatic test_async_reset();
    // commit_valid is 01 and one entry is outstanding here
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (commit_valid !== 2'b00 || commit_rd !== '0 || commit_data !== '0 || count !== 5'd0 || alloc_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL async_reset got cv=%b rd=%h data=%h count=%0d ready=%b want zeros/ready", commit_valid, commit_rd, commit_data, count, alloc_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

`ifdef ROB_FLUSH_EN
  task automatic test_flush();
    apply_reset();
    set_alloc(2'b11, 6'd1, 6'd1, 6'd0, 6'd0, 2'b11);
    tick();
    tick();
    set_alloc(2'b01, 6'd1, 6'd1, 6'd0, 6'd0, 2'b11);
    tick();
    tests_run++;
    if (count !== 5'd5) begin tests_failed++; $display("[TB] FAIL t6_count5 got %0d want 5", count); end
    set_alloc(2'b11, 6'd1, 6'd1, 6'd0, 6'd0, 2'b11);
    flush = 1'b1;
    tick();
    idle_inputs();
    tests_run++;
    if (count !== 5'd0 || alloc_idx !== 8'h10 || commit_valid !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL t6_flush got count=%0d idx=%h cv=%b want 0/10/00", count, alloc_idx, commit_valid);
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    idle_inputs();
    test_reset();
    test_basic_commit();
    test_partial_commit();
    test_fill();
    test_wrap();
    test_wb_collision();
    test_async_reset();
`ifdef ROB_FLUSH_EN
    test_flush();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
